// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the CPU-to-Wishbone bridge: the bridge state encoding,
// the default read data returned for an aborted cycle, and the width of the
// no-responder timeout counter.
// No ports (package).
// -----------------------------------------------------------------------------
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } wb_state_t;

    localparam logic [31:0] WB_ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    localparam int WB_TO_CTR_W = 8;

endpackage

// File: rtl/wb_timeout_ctr.sv
// -----------------------------------------------------------------------------
// wb_timeout_ctr
// Counts Wishbone bus cycles that pass without an acknowledge so the bridge can
// give up on an address nobody decodes.
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous reset, active-low
//   clear  in   zero the count (bridge entering a new bus cycle)
//   en     in   advance the count by one this cycle
//   last   in   terminal value to compare against
//   tc     out  count currently equals last
// -----------------------------------------------------------------------------
module wb_timeout_ctr
    import wb_pkg::*;
#(
    parameter int W = WB_TO_CTR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic         tc
);

    logic [W-1:0] count;

    // Clear has priority so a fresh cycle always starts from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == last);

endmodule

// File: rtl/wb_master_bridge.sv
// -----------------------------------------------------------------------------
// wb_master_bridge
// Turns a single-cycle CPU load/store request into one classic Wishbone read or
// write cycle. The request is registered on accept, cyc_o/stb_o are held until
// the responder acks, read data is captured and a one-cycle cpu_done pulse is
// returned. Requests arriving while busy are dropped.
//
// Optional feature macro: WB_TIMEOUT_EN
//   When defined, a bus cycle with no ack for TIMEOUT_CYCLES cycles is aborted:
//   cpu_done is raised with cpu_err=1 and reads return ERR_DATA. An ack on the
//   expiry cycle still completes normally. When undefined, the bridge waits
//   forever and cpu_err is constant 0.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-low
//   cpu_req    in   request strobe, sampled only while idle
//   cpu_we     in   1=store, 0=load
//   cpu_adr    in   byte address [31:0]
//   cpu_dat_w  in   store data [31:0]
//   cpu_sel    in   byte lanes [3:0]
//   cpu_busy   out  bridge not idle
//   cpu_done   out  one-cycle completion pulse
//   cpu_dat_r  out  load data, held until the next load completes
//   cpu_err    out  completion was an abort
//   adr_o      out  Wishbone word address
//   dat_o      out  Wishbone write data
//   sel_o      out  Wishbone byte selects
//   we_o       out  Wishbone write enable
//   cyc_o      out  Wishbone cycle
//   stb_o      out  Wishbone strobe (same as cyc_o)
//   dat_i      in   Wishbone read data
//   ack_i      in   Wishbone acknowledge (may combinationally follow stb_o)
// -----------------------------------------------------------------------------
module wb_master_bridge
    import wb_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_DATA       = WB_ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_adr,
    input  logic [31:0] cpu_dat_w,
    input  logic [3:0]  cpu_sel,
    output logic        cpu_busy,
    output logic        cpu_done,
    output logic [31:0] cpu_dat_r,
    output logic        cpu_err,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    output logic [3:0]  sel_o,
    output logic        we_o,
    output logic        cyc_o,
    output logic        stb_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i
);

    wb_state_t state;
    wb_state_t state_next;
    logic      accept;
    logic      ack_bus;
    logic      abort;
    logic      expire;
    logic      err_q;

`ifdef WB_TIMEOUT_EN
    localparam logic [WB_TO_CTR_W-1:0] TIMEOUT_LAST = WB_TO_CTR_W'(TIMEOUT_CYCLES - 1);

    // Counter restarts on every accept and only advances on unacknowledged
    // bus cycles, so terminal count lands on the last allowed strobe cycle.
    wb_timeout_ctr #(
        .W (WB_TO_CTR_W)
    ) u_timeout_ctr (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .en    ((state == BUS) && !ack_i),
        .last  (TIMEOUT_LAST),
        .tc    (expire)
    );
`else
    assign expire = 1'b0;
`endif

    // The two low address bits never reach the bus and the timeout length only
    // matters when the timeout feature is built in.
    logic unused_ok;
    assign unused_ok = ^cpu_adr[1:0] ^ (TIMEOUT_CYCLES != 0);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the single-cycle strobes that steer the datapath.
    // An ack always wins over a simultaneous timeout expiry.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        ack_bus    = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    accept     = 1'b1;
                    state_next = BUS;
                end
            end
            BUS: begin
                if (ack_i) begin
                    ack_bus    = 1'b1;
                    state_next = DONE;
                end else if (expire) begin
                    abort      = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bus-side request registers load on accept and stay put for the whole
    // cycle. Read data updates only when a load finishes; stores leave it
    // alone. err_q is high exactly during the DONE that follows an abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            adr_o     <= '0;
            dat_o     <= '0;
            sel_o     <= '0;
            we_o      <= 1'b0;
            cpu_dat_r <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                adr_o <= {cpu_adr[31:2], 2'b00};
                dat_o <= cpu_dat_w;
                sel_o <= cpu_sel;
                we_o  <= cpu_we;
            end
            if (ack_bus && !we_o) begin
                cpu_dat_r <= dat_i;
            end else if (abort && !we_o) begin
                cpu_dat_r <= ERR_DATA;
            end
            err_q <= abort;
        end
    end

    assign cpu_busy = (state != IDLE);
    assign cpu_done = (state == DONE);
    assign cyc_o    = (state == BUS);
    assign stb_o    = (state == BUS);
    assign cpu_err  = err_q;

endmodule
